alu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the small nibble ALU in the TinyTapeout top level.
//  - Accepts one command {a, b, op} over a valid/ready handshake.
//  - ADD/SUB complete in a single cycle; MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
//  - Holds the result until the consumer takes it.
//  - Sits between the pin-decode logic (ui_in/uio_in) and the uo_out drive.

---
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle nibble ALU sequencer: ADD/SUB in one cycle, MUL/DIV bit-serial.
// Optional ALU_SEQ_ACCUM_EN adds cmd_acc to reuse the last taken result as A.
module alu_seq_ctrl #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  input  logic [1:0]      cmd_op,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic            cmd_acc,
`endif
  output logic            res_valid,
  input  logic            res_ready,
  output logic [2*DW-1:0] res_data,
  output logic            res_err,
  output logic            busy
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] wrk_q, wrk_d;
  logic [2*DW-1:0] res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic [DW-1:0]   op_a;

`ifdef ALU_SEQ_ACCUM_EN
  logic [DW-1:0]   acc_q, acc_d;
  assign op_a = cmd_acc ? acc_q : cmd_a;
`else
  assign op_a = cmd_a;
`endif

  // wrk holds the partial product, or {remainder, dividend/quotient} for DIV
  logic [2*DW-1:0] mul_nxt;
  logic [2*DW-1:0] div_nxt;
  logic [DW:0]     rem_t;
  logic [DW:0]     rem_n;
  logic [DW:0]     lo_sh;
  logic            q_bit;
  logic            last;

  always_comb begin
    last    = (cnt_q == CNT_LAST);
    mul_nxt = wrk_q;
    if (b_q[cnt_q])
      mul_nxt = wrk_q + ({{DW{1'b0}}, a_q} << cnt_q);
    rem_t   = {wrk_q[2*DW-1:DW], wrk_q[DW-1]};
    q_bit   = (rem_t >= {1'b0, b_q});
    rem_n   = q_bit ? (rem_t - {1'b0, b_q}) : rem_t;
    lo_sh   = {wrk_q[DW-1:0], q_bit};
    div_nxt = {rem_n[DW-1:0], lo_sh[DW-1:0]};
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    wrk_d      = wrk_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
`ifdef ALU_SEQ_ACCUM_EN
    acc_d      = acc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d     = op_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          cnt_d   = '0;
          wrk_d   = (cmd_op == OP_DIV) ? {{DW{1'b0}}, op_a} : '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            res_data_d = {{DW{1'b0}}, a_q} + {{DW{1'b0}}, b_q};
            res_err_d  = 1'b0;
            state_d    = S_DONE;
          end
          OP_SUB: begin
            res_data_d = {{DW{1'b0}}, a_q} - {{DW{1'b0}}, b_q};
            res_err_d  = 1'b0;
            state_d    = S_DONE;
          end
          OP_MUL: begin
            wrk_d = mul_nxt;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
              cnt_d      = '0;
              res_data_d = mul_nxt;
              res_err_d  = 1'b0;
              state_d    = S_DONE;
            end
          end
          OP_DIV: begin
            wrk_d = div_nxt;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
              cnt_d      = '0;
              res_data_d = div_nxt;
              res_err_d  = (b_q == '0);
              state_d    = S_DONE;
            end
          end
        endcase
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
`ifdef ALU_SEQ_ACCUM_EN
          acc_d   = res_data_q[DW-1:0];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      wrk_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      wrk_q      <= wrk_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
`ifdef ALU_SEQ_ACCUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed cases plus random commands
// checked against an arithmetic reference model.
module tb_alu_seq_ctrl;
  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_a = '0;
  logic [3:0]   cmd_b = '0;
  logic [1:0]   cmd_op = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [7:0]   res_data;
  logic         res_err;
  logic         busy;
`ifdef ALU_SEQ_ACCUM_EN
  logic         cmd_acc = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [3:0] acc_m = '0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
`ifdef ALU_SEQ_ACCUM_EN
    .cmd_acc   (cmd_acc),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // returns {err, data}
  function automatic logic [8:0] model(input logic [1:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    int ai;
    int bi;
    int r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      2'd0: r = ai + bi;
      2'd1: r = ai * bi;
      2'd2: r = (ai - bi) & 255;
      default: begin
        if (bi == 0) return {1'b1, a, 4'hF};
        r = ((ai % bi) << 4) | (ai / bi);
      end
    endcase
    return {1'b0, 8'(r)};
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input bit acc,
                        input int hold, input bit poke);
    int n;
    logic [3:0] ae;
    logic [8:0] e;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_idle", 16'(cmd_ready), 16'd1);
`ifdef ALU_SEQ_ACCUM_EN
    ae = acc ? acc_m : a;
    cmd_acc = acc;
`else
    ae = a;
    if (acc) ae = a;
`endif
    e = model(op, ae, b);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(posedge clk); #1;
    if (poke) begin
      cmd_a = ~a;
      cmd_b = ~b;
      cmd_op = ~op;
    end else begin
      cmd_valid = 1'b0;
    end
    check("busy_exec", {busy, cmd_ready}, 16'b10);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 16'(n), op[0] ? 16'(DW) : 16'd1);
    check("res_data", 16'(res_data), 16'(e[7:0]));
    check("res_err", 16'(res_err), 16'(e[8]));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold", {7'd0, res_valid, res_data}, {7'd0, 1'b1, e[7:0]});
      check("hold_rdy", {busy, cmd_ready}, 16'b10);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check("taken", {res_valid, cmd_ready, busy}, 16'b010);
    acc_m = e[3:0];
  endtask

  initial begin
    #2;
    check("rst_state", {cmd_ready, res_valid, res_err, busy}, 16'b1000);
    check("rst_data", 16'(res_data), 16'h00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(2'd0, 4'h9, 4'h8, 1'b0, 0, 1'b0);
    // Reset mid-MUL with the iteration counter at 2
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 4'h5; cmd_b = 4'h6;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_mul_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check("arst_state", {cmd_ready, res_valid, res_err, busy}, 16'b1000);
    check("arst_data", 16'(res_data), 16'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_m = '0;
    @(posedge clk); #1;
    check("post_rst", {cmd_ready, res_valid, busy}, 16'b100);

    do_cmd(2'd0, 4'h9, 4'h8, 1'b0, 0, 1'b0);
    do_cmd(2'd1, 4'hF, 4'hF, 1'b0, 3, 1'b0);
    do_cmd(2'd3, 4'hD, 4'h3, 1'b0, 0, 1'b0);
    do_cmd(2'd3, 4'h7, 4'h0, 1'b0, 1, 1'b0);
    do_cmd(2'd2, 4'h3, 4'h5, 1'b0, 2, 1'b1);
    do_cmd(2'd1, 4'h0, 4'hA, 1'b0, 0, 1'b1);
    do_cmd(2'd3, 4'h0, 4'h0, 1'b0, 0, 1'b0);
    do_cmd(2'd3, 4'hF, 4'h1, 1'b0, 0, 1'b0);

`ifdef ALU_SEQ_ACCUM_EN
    do_cmd(2'd0, 4'h2, 4'h3, 1'b0, 0, 1'b0);
    do_cmd(2'd0, 4'hE, 4'h4, 1'b1, 0, 1'b0);
    check("acc_sum", 16'(acc_m), 16'h9);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_m = '0;
    @(posedge clk); #1;
    do_cmd(2'd0, 4'hC, 4'h1, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
             bit'($urandom_range(0, 1)), $urandom_range(0, 2),
             bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
